mem_access_unit: RTL and testbench

Memory-access/writeback stage sitting between the ALU and the register bank. Accepts one ALU result per instruction, performs a load or store against data memory through a req/ack handshake, and drives the register bank's `write_data`, `destination`, `write` and `WMFC` inputs. Ensures the register bank commits only after memory completes. Generates byte enables, extracts lanes and sign/zero-extends load data.

---
 rtl/mau_pkg.sv | 11 +
 rtl/mau_lane_align.sv | 29 ++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared FSM state, op and size encodings for mem_access_unit.
// No ports; imported by mem_access_unit and mau_lane_align.
package mau_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational lane logic for mem_access_unit.
// Ports: size/addr_lo select access width and lane; misalign flags an illegal
// alignment; be/wdata are the byte enables and lane-replicated store data;
// rdata/unsigned_ld produce the extracted, extended load_data.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        misalign = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? addr_lo[0] : |addr_lo;
        be = size == SZ_BYTE ? 4'b0001 << addr_lo : size == SZ_HALF ? 4'b0011 << addr_lo : 4'b1111;
        wdata = size == SZ_BYTE ? {4{store_data[7:0]}} : size == SZ_HALF ? {2{store_data[15:0]}} : store_data;
        lb = rdata[{addr_lo, 3'b000} +: 8];
        lh = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = size == SZ_BYTE ? {{24{~unsigned_ld & lb[7]}}, lb}
                  : size == SZ_HALF ? {{16{~unsigned_ld & lh[15]}}, lh} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access/writeback stage between ALU and register bank.
// Ports: start/op/size/unsigned_ld/alu_result/store_data/dest_in take one
// instruction while ready; mem_req/mem_we/mem_addr/mem_be/mem_wdata and
// mem_rdata/mem_ack form the data-memory req/ack handshake; write_data,
// destination, write and WMFC drive the register bank in the WB cycle;
// err_misalign/err_timeout are one-cycle error pulses.
// Optional macro MAU_TIMEOUT_EN aborts a request after TIMEOUT_CYCLES REQ cycles.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] write_data,
    output logic [3:0]  destination,
    output logic        write,
    output logic        WMFC,
    output logic        err_misalign,
    output logic        err_timeout
);
    state_t      state, state_n;
    logic [1:0]  op_q, size_q;
    logic        uns_q;
    logic [31:0] addr_q, sd_q;
    logic [3:0]  dest_q;
    logic [1:0]  a_size, a_lo;
    logic        misalign, is_mem, alu_go, mem_go, ack_ok, tmo;
    logic [3:0]  be;
    logic [31:0] wdata, load_data;

    // In IDLE the aligner sees live inputs for the misalign check; afterwards the latched copy.
    assign a_size = state == IDLE ? size : size_q;
    assign a_lo   = state == IDLE ? alu_result[1:0] : addr_q[1:0];

    mau_lane_align u_align (
        .size       (a_size),
        .addr_lo    (a_lo),
        .unsigned_ld(uns_q),
        .store_data (sd_q),
        .rdata      (mem_rdata),
        .misalign   (misalign),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    always_comb begin
        is_mem = op == OP_LOAD || op == OP_STORE;
        alu_go = state == IDLE && start && !is_mem;
        mem_go = state == IDLE && start && is_mem && !misalign;
        ack_ok = state == REQ && mem_ack;
        state_n = alu_go ? WB : mem_go ? REQ : ack_ok ? WB : (tmo || state == WB) ? IDLE : state;
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            sd_q         <= '0;
            dest_q       <= '0;
            write_data   <= '0;
            destination  <= '0;
            write        <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_q   <= op;
                size_q <= size;
                uns_q  <= unsigned_ld;
                addr_q <= alu_result;
                sd_q   <= store_data;
                dest_q <= dest_in;
            end
            // Register-bank outputs are loaded only on the edge entering WB, so they read 0 elsewhere.
            write_data   <= alu_go ? alu_result : (ack_ok && op_q == OP_LOAD) ? load_data : '0;
            destination  <= alu_go ? dest_in : ack_ok ? dest_q : '0;
            write        <= alu_go || (ack_ok && op_q == OP_LOAD);
            err_misalign <= state == IDLE && start && is_mem && misalign;
        end
    end

`ifdef MAU_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    // Ack on the limit edge takes priority through ack_ok in the next-state chain.
    assign tmo = state == REQ && tmo_cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt     <= state == REQ ? tmo_cnt + 16'd1 : '0;
            err_timeout <= tmo && !mem_ack;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = |TIMEOUT_CYCLES;
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign ready     = state == IDLE;
    assign mem_req   = state == REQ;
    assign mem_we    = mem_req && op_q == OP_STORE;
    assign mem_addr  = mem_req ? addr_q[31:2] : '0;
    assign mem_be    = mem_req ? be : '0;
    assign mem_wdata = mem_we ? wdata : '0;
    assign WMFC      = state == WB;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven, scoreboarded bench for mem_access_unit.
module tb_mem_access_unit;
    import mau_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [3:0]  dest;
        int          k;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wd;
        logic        wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  size = '0;
    logic        unsigned_ld = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [3:0]  dest_in = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        ready, mem_req, mem_we, write, WMFC, err_misalign, err_timeout;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be, destination;
    logic [31:0] mem_wdata, write_data;

    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t e_m;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
        .unsigned_ld(unsigned_ld), .alu_result(alu_result), .store_data(store_data),
        .dest_in(dest_in), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .write_data(write_data),
        .destination(destination), .write(write), .WMFC(WMFC),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every WB cycle must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (!reset && WMFC) begin
            if (sb.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_wb: got WMFC=1 expected no writeback");
            end else begin
                e_m = sb.pop_front();
                chk("wb_write", {31'b0, write}, {31'b0, e_m.wr});
                chk("wb_dest", {28'b0, destination}, {28'b0, e_m.dest});
                if (e_m.wr) chk("wb_data", write_data, e_m.wd);
            end
        end else if (!reset && write) begin
            nvec++;
            nfail++;
            $display("FAIL write_outside_wb: got write=1 expected 0");
        end
    end

    task automatic run(input vec_t v);
        int   n;
        int   t0;
        logic is_m;
        is_m = v.op == OP_LOAD || v.op == OP_STORE;
        @(negedge clk);
        start = 1'b1; op = v.op; size = v.size; unsigned_ld = v.uns;
        alu_result = v.addr; store_data = v.sd; dest_in = v.dest;
        if (!v.mis) sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        if (v.mis) begin
            chk("misalign_pulse", {31'b0, err_misalign}, 32'd1);
            chk("misalign_no_req", {31'b0, mem_req}, 32'd0);
            chk("misalign_ready", {31'b0, ready}, 32'd1);
            @(negedge clk);
            chk("misalign_pulse_end", {31'b0, err_misalign}, 32'd0);
            chk("misalign_no_wb", {31'b0, WMFC}, 32'd0);
            return;
        end
        if (is_m) begin
            chk("req", {31'b0, mem_req}, 32'd1);
            chk("req_ready", {31'b0, ready}, 32'd0);
            chk("req_we", {31'b0, mem_we}, {31'b0, v.op == OP_STORE});
            chk("req_be", {28'b0, mem_be}, {28'b0, v.be});
            chk("req_addr", {2'b0, mem_addr}, v.addr >> 2);
            if (v.op == OP_STORE) chk("req_wdata", mem_wdata, v.wdata);
            for (int i = 1; i < v.k; i++) begin
                if (i == 1) begin
                    start = 1'b1; op = OP_ALU; alu_result = 32'hFFFF_FFFF; size = SZ_BYTE;
                end
                @(negedge clk);
                start = 1'b0;
            end
            chk("req_hold", {31'b0, mem_req}, 32'd1);
            chk("req_hold_be", {28'b0, mem_be}, {28'b0, v.be});
            chk("req_hold_addr", {2'b0, mem_addr}, v.addr >> 2);
`ifndef MAU_TIMEOUT_EN
            chk("no_timeout", {31'b0, err_timeout}, 32'd0);
`endif
            mem_ack = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        n = 0;
        while (!WMFC && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - t0, v.k);
        @(negedge clk);
        chk("ready_after_wb", {31'b0, ready}, 32'd1);
        chk("wmfc_one_cycle", {31'b0, WMFC}, 32'd0);
    endtask

    initial begin
        int n;
        vecs.push_back('{OP_ALU,   SZ_WORD, 1'b0, 32'h1234_5678, 32'h0,         32'h0,         4'd5,  0, 1'b0, 4'b0000, 32'h0,         32'h1234_5678, 1'b1});
        vecs.push_back('{OP_LOAD,  SZ_BYTE, 1'b0, 32'h0000_0102, 32'h0,         32'h0080_0000, 4'd2,  3, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FF80, 1'b1});
        vecs.push_back('{OP_STORE, SZ_HALF, 1'b0, 32'h0000_0106, 32'hAAAA_BEEF, 32'h0,         4'd3,  1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0});
        vecs.push_back('{OP_LOAD,  SZ_WORD, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         4'd4,  0, 1'b1, 4'b0000, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{OP_LOAD,  SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0,         32'h9A00_0000, 4'd6,  2, 1'b0, 4'b1000, 32'h0,         32'h0000_009A, 1'b1});
        vecs.push_back('{OP_LOAD,  SZ_HALF, 1'b0, 32'h0000_0202, 32'h0,         32'h8001_1234, 4'd7,  1, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b1});
        vecs.push_back('{OP_LOAD,  SZ_HALF, 1'b1, 32'h0000_0200, 32'h0,         32'h8001_F234, 4'd8,  1, 1'b0, 4'b0011, 32'h0,         32'h0000_F234, 1'b1});
        vecs.push_back('{OP_LOAD,  2'b11,   1'b0, 32'h0000_03FC, 32'h0,         32'hDEAD_BEEF, 4'd9,  4, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{OP_STORE, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h1234_56A5, 32'h0,         4'd1,  2, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0});
        vecs.push_back('{OP_STORE, SZ_WORD, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         4'd2,  1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0});
        vecs.push_back('{2'b11,    SZ_WORD, 1'b0, 32'hFFFF_0001, 32'h0,         32'h0,         4'd0,  0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_0001, 1'b1});
        vecs.push_back('{OP_STORE, SZ_HALF, 1'b0, 32'h0000_0103, 32'h1111_2222, 32'h0,         4'd3,  0, 1'b1, 4'b0000, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{OP_LOAD,  SZ_BYTE, 1'b0, 32'h0000_0100, 32'h0,         32'h1122_337F, 4'd15, 2, 1'b0, 4'b0001, 32'h0,         32'h0000_007F, 1'b1});
        vecs.push_back('{OP_LOAD,  SZ_HALF, 1'b0, 32'h0000_0002, 32'h0,         32'h7FFF_0000, 4'd14, 1, 1'b0, 4'b1100, 32'h0,         32'h0000_7FFF, 1'b1});
`ifndef MAU_TIMEOUT_EN
        vecs.push_back('{OP_LOAD,  SZ_WORD, 1'b0, 32'h0000_0080, 32'h0,         32'h0BAD_F00D, 4'd10, 300, 1'b0, 4'b1111, 32'h0,       32'h0BAD_F00D, 1'b1});
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_dest", {28'b0, destination}, 32'd0);
        chk("rst_write", {31'b0, write}, 32'd0);
        chk("rst_wmfc", {31'b0, WMFC}, 32'd0);
        chk("rst_misalign", {31'b0, err_misalign}, 32'd0);
        chk("rst_timeout", {31'b0, err_timeout}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        @(negedge clk);
        start = 1'b1; op = OP_LOAD; size = SZ_WORD; alu_result = 32'h40; dest_in = 4'd12;
        @(negedge clk);
        start = 1'b0;
        chk("midreq_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreq_req_drop", {31'b0, mem_req}, 32'd0);
        chk("midreq_ready", {31'b0, ready}, 32'd1);
        chk("midreq_no_wb", {31'b0, WMFC}, 32'd0);
        chk("midreq_no_err", {31'b0, err_misalign}, 32'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_ready", {31'b0, ready}, 32'd1);
        chk("stray_ack_no_wb", {31'b0, WMFC}, 32'd0);
        chk("stray_ack_no_req", {31'b0, mem_req}, 32'd0);

`ifdef MAU_TIMEOUT_EN
        @(negedge clk);
        start = 1'b1; op = OP_LOAD; size = SZ_WORD; alu_result = 32'h44; dest_in = 4'd11;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem_req && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, 32'd4);
        chk("timeout_pulse", {31'b0, err_timeout}, 32'd1);
        chk("timeout_ready", {31'b0, ready}, 32'd1);
        chk("timeout_no_wb", {31'b0, WMFC}, 32'd0);
        @(negedge clk);
        chk("timeout_pulse_end", {31'b0, err_timeout}, 32'd0);
        chk("timeout_no_wb2", {31'b0, WMFC}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
